// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : game_flow_ctrl_if
// Brief   : Request/status bundle between input decoder and game sequencer.
// Revision: 1.0
// ============================================================================
interface game_flow_ctrl_if #(
    parameter int SCORE_W = 20,
    parameter int LEVEL_W = 8,
    parameter int LIVES_W = 4
);
    logic               i_game_start;
    logic               i_game_pause;
    logic               i_board_reload_done;
    logic               i_pacman_eaten;
    logic               i_dot_clear;
    logic [SCORE_W-1:0] i_score;
    logic [3:0]         o_game_state;
    logic               o_board_reload;
    logic               o_ghost_reload;
    logic               o_pacman_reload;
    logic               o_extra_life;
    logic [LEVEL_W-1:0] o_level;
    logic [LIVES_W-1:0] o_lives;

    modport master (
        output i_game_start, i_game_pause, i_board_reload_done,
               i_pacman_eaten, i_dot_clear, i_score,
        input  o_game_state, o_board_reload, o_ghost_reload,
               o_pacman_reload, o_extra_life, o_level, o_lives
    );

    modport slave (
        input  i_game_start, i_game_pause, i_board_reload_done,
               i_pacman_eaten, i_dot_clear, i_score,
        output o_game_state, o_board_reload, o_ghost_reload,
               o_pacman_reload, o_extra_life, o_level, o_lives
    );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_flow_ctrl
// Brief   : Pac-Man game sequencer: flow FSM, reload strobes, level and lives.
// Revision: 1.0
// ============================================================================
module game_flow_ctrl #(
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 5,
    parameter int LIVES_W          = 4,
    parameter int LEVEL_W          = 8,
    parameter int MAX_LEVEL        = 255,
    parameter int READY_CYCLES     = 120,
    parameter int DYING_CYCLES     = 90,
    parameter int SCORE_W          = 20,
    parameter int EXTRA_LIFE_SCORE = 10000
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    game_flow_ctrl_if.slave bus
);
    localparam int c_timer_max = (READY_CYCLES > DYING_CYCLES) ? READY_CYCLES : DYING_CYCLES;
    localparam int c_timer_w   = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RELOAD   = 4'd1,
        ST_READY    = 4'd2,
        ST_PLAY     = 4'd3,
        ST_PAUSE    = 4'd4,
        ST_DYING    = 4'd5,
        ST_CLEAR    = 4'd6,
        ST_GAMEOVER = 4'd7
    } state_t;

    state_t               state_q, state_d;
    logic [c_timer_w-1:0] timer_q, timer_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 xl_flag_q, xl_flag_d;
    logic                 board_reload_q, board_reload_d;
    logic                 ghost_reload_q, ghost_reload_d;
    logic                 pacman_reload_q, pacman_reload_d;
    logic                 extra_life_q, extra_life_d;

    logic                 w_award;
    logic                 w_dec;
    logic [LIVES_W-1:0]   w_lives_dec;
    logic [LIVES_W-1:0]   w_lives_next;

    // Decrement is applied before the award so a same-cycle hit at the
    // saturation limit leaves lives unchanged.
    always_comb begin
        w_award = (state_q == ST_READY || state_q == ST_PLAY || state_q == ST_PAUSE ||
                   state_q == ST_DYING || state_q == ST_CLEAR) &&
                  !xl_flag_q && (bus.i_score >= SCORE_W'(EXTRA_LIFE_SCORE));
        w_dec   = (state_q == ST_PLAY) && !bus.i_game_pause && bus.i_pacman_eaten;
        w_lives_dec  = (w_dec && lives_q != '0) ? lives_q - 1'b1 : lives_q;
        w_lives_next = (w_award && w_lives_dec != LIVES_W'(MAX_LIVES)) ?
                       w_lives_dec + 1'b1 : w_lives_dec;
    end

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        level_d         = level_q;
        lives_d         = w_lives_next;
        xl_flag_d       = xl_flag_q | w_award;
        board_reload_d  = board_reload_q;
        ghost_reload_d  = 1'b0;
        pacman_reload_d = 1'b0;
        extra_life_d    = w_award;

        case (state_q)
            ST_IDLE: begin
                board_reload_d = 1'b0;
                if (bus.i_game_start) begin
                    state_d        = ST_RELOAD;
                    board_reload_d = 1'b1;
                    level_d        = LEVEL_W'(1);
                    lives_d        = LIVES_W'(START_LIVES);
                    xl_flag_d      = 1'b0;
                end
            end
            ST_RELOAD: begin
                board_reload_d = 1'b1;
                if (bus.i_board_reload_done) begin
                    state_d         = ST_READY;
                    board_reload_d  = 1'b0;
                    ghost_reload_d  = 1'b1;
                    pacman_reload_d = 1'b1;
                    timer_d         = c_timer_w'(READY_CYCLES - 1);
                end
            end
            ST_READY: begin
                if (timer_q == '0) state_d = ST_PLAY;
                else               timer_d = timer_q - 1'b1;
            end
            ST_PLAY: begin
                if (bus.i_game_pause) begin
                    state_d = ST_PAUSE;
                end else if (bus.i_pacman_eaten) begin
                    state_d = ST_DYING;
                    timer_d = c_timer_w'(DYING_CYCLES - 1);
                end else if (bus.i_dot_clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_PAUSE: begin
                if (bus.i_game_pause) state_d = ST_PLAY;
            end
            ST_DYING: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (w_lives_next == '0) begin
                    state_d = ST_GAMEOVER;
                end else begin
                    state_d         = ST_READY;
                    ghost_reload_d  = 1'b1;
                    pacman_reload_d = 1'b1;
                    timer_d         = c_timer_w'(READY_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (bus.i_game_start) begin
                    state_d        = ST_RELOAD;
                    board_reload_d = 1'b1;
                    if (level_q != LEVEL_W'(MAX_LEVEL)) level_d = level_q + 1'b1;
                end
            end
            ST_GAMEOVER: begin
                if (bus.i_game_start) state_d = ST_IDLE;
            end
            default: begin
                state_d        = ST_IDLE;
                board_reload_d = 1'b0;
                timer_d        = '0;
                xl_flag_d      = 1'b0;
                extra_life_d   = 1'b0;
                lives_d        = lives_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            level_q         <= LEVEL_W'(1);
            lives_q         <= LIVES_W'(START_LIVES);
            xl_flag_q       <= 1'b0;
            board_reload_q  <= 1'b0;
            ghost_reload_q  <= 1'b0;
            pacman_reload_q <= 1'b0;
            extra_life_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            level_q         <= level_d;
            lives_q         <= lives_d;
            xl_flag_q       <= xl_flag_d;
            board_reload_q  <= board_reload_d;
            ghost_reload_q  <= ghost_reload_d;
            pacman_reload_q <= pacman_reload_d;
            extra_life_q    <= extra_life_d;
        end
    end

    assign bus.o_game_state    = state_q;
    assign bus.o_board_reload  = board_reload_q;
    assign bus.o_ghost_reload  = ghost_reload_q;
    assign bus.o_pacman_reload = pacman_reload_q;
    assign bus.o_extra_life    = extra_life_q;
    assign bus.o_level         = level_q;
    assign bus.o_lives         = lives_q;
endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_flow_ctrl
// Brief   : Directed self-checking bench for game_flow_ctrl.
// Revision: 1.0
// ============================================================================
module tb_game_flow_ctrl;
    localparam int READY_CYCLES = 120;
    localparam int DYING_CYCLES = 90;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_flow_ctrl_if #(.SCORE_W(20), .LEVEL_W(8), .LIVES_W(4)) bus ();
    game_flow_ctrl_if #(.SCORE_W(20), .LEVEL_W(8), .LIVES_W(4)) bus_sat ();

    // Second instance starts at the lives limit to observe award saturation.
    assign bus_sat.i_game_start        = bus.i_game_start;
    assign bus_sat.i_game_pause        = bus.i_game_pause;
    assign bus_sat.i_board_reload_done = bus.i_board_reload_done;
    assign bus_sat.i_pacman_eaten      = bus.i_pacman_eaten;
    assign bus_sat.i_dot_clear         = bus.i_dot_clear;
    assign bus_sat.i_score             = bus.i_score;

    game_flow_ctrl #(
        .START_LIVES(3), .MAX_LIVES(5), .LIVES_W(4), .LEVEL_W(8), .MAX_LEVEL(255),
        .READY_CYCLES(READY_CYCLES), .DYING_CYCLES(DYING_CYCLES),
        .SCORE_W(20), .EXTRA_LIFE_SCORE(10000)
    ) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    game_flow_ctrl #(
        .START_LIVES(5), .MAX_LIVES(5), .LIVES_W(4), .LEVEL_W(8), .MAX_LEVEL(255),
        .READY_CYCLES(READY_CYCLES), .DYING_CYCLES(DYING_CYCLES),
        .SCORE_W(20), .EXTRA_LIFE_SCORE(10000)
    ) u_dut_sat (.i_clk(clk), .i_rst(rst), .bus(bus_sat.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.i_game_start = 1'b1; step(1); bus.i_game_start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.i_board_reload_done = 1'b1; step(1); bus.i_board_reload_done = 1'b0;
    endtask

    task automatic pulse_eaten();
        bus.i_pacman_eaten = 1'b1; step(1); bus.i_pacman_eaten = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.i_dot_clear = 1'b1; step(1); bus.i_dot_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_game_start        = 1'b0;
        bus.i_game_pause        = 1'b0;
        bus.i_board_reload_done = 1'b0;
        bus.i_pacman_eaten      = 1'b0;
        bus.i_dot_clear         = 1'b0;
        bus.i_score             = '0;
        step(2);
        rst = 1'b0;

        check("rst_state", bus.o_game_state, 0);
        check("rst_board", bus.o_board_reload, 0);
        check("rst_ghost", bus.o_ghost_reload, 0);
        check("rst_extra", bus.o_extra_life, 0);
        check("rst_level", bus.o_level, 1);
        check("rst_lives", bus.o_lives, 3);

        // New game: RELOAD held five cycles before done.
        pulse_start();
        check("reload_state", bus.o_game_state, 1);
        check("reload_board", bus.o_board_reload, 1);
        step(4);
        check("reload_hold", bus.o_game_state, 1);
        pulse_done();
        check("ready_state", bus.o_game_state, 2);
        check("ready_board", bus.o_board_reload, 0);
        check("ready_ghost", bus.o_ghost_reload, 1);
        check("ready_pacman", bus.o_pacman_reload, 1);

        bus.i_pacman_eaten = 1'b1;
        step(3);
        bus.i_pacman_eaten = 1'b0;
        check("ready_eaten_lives", bus.o_lives, 3);
        check("ready_eaten_state", bus.o_game_state, 2);
        check("ghost_one_shot", bus.o_ghost_reload, 0);
        step(READY_CYCLES - 4);
        check("ready_last", bus.o_game_state, 2);
        step(1);
        check("play_entry", bus.o_game_state, 3);
        check("play_level", bus.o_level, 1);
        check("play_lives", bus.o_lives, 3);

        // Pause beats eaten in the same cycle.
        bus.i_game_pause = 1'b1; bus.i_pacman_eaten = 1'b1;
        step(1);
        bus.i_game_pause = 1'b0; bus.i_pacman_eaten = 1'b0;
        check("pause_state", bus.o_game_state, 4);
        check("pause_lives", bus.o_lives, 3);
        bus.i_pacman_eaten = 1'b1; bus.i_dot_clear = 1'b1;
        step(3);
        bus.i_pacman_eaten = 1'b0; bus.i_dot_clear = 1'b0;
        check("pause_ignore", bus.o_game_state, 4);
        check("pause_ignore_lives", bus.o_lives, 3);
        bus.i_game_pause = 1'b1; step(1); bus.i_game_pause = 1'b0;
        check("unpause", bus.o_game_state, 3);

        // Extra life on crossing the threshold, once only.
        bus.i_score = 20'd9999; step(1);
        check("xl_below", bus.o_extra_life, 0);
        bus.i_score = 20'd10000; step(1);
        check("xl_pulse", bus.o_extra_life, 1);
        check("xl_lives", bus.o_lives, 4);
        check("xl_sat_pulse", bus_sat.o_extra_life, 1);
        check("xl_sat_lives", bus_sat.o_lives, 5);
        step(1);
        check("xl_one_shot", bus.o_extra_life, 0);
        bus.i_score = 20'd20000; step(2);
        check("xl_no_second", bus.o_extra_life, 0);
        check("xl_no_second_sat", bus_sat.o_extra_life, 0);
        check("xl_lives_hold", bus.o_lives, 4);
        bus.i_score = '0;

        // Death with lives remaining.
        pulse_eaten();
        check("dying_state", bus.o_game_state, 5);
        check("dying_lives", bus.o_lives, 3);
        step(DYING_CYCLES - 1);
        check("dying_last", bus.o_game_state, 5);
        step(1);
        check("respawn_state", bus.o_game_state, 2);
        check("respawn_ghost", bus.o_ghost_reload, 1);
        check("respawn_pacman", bus.o_pacman_reload, 1);
        check("respawn_board", bus.o_board_reload, 0);
        step(READY_CYCLES - 1);
        check("respawn_ready_last", bus.o_game_state, 2);
        step(1);
        check("respawn_play", bus.o_game_state, 3);

        // Lose remaining lives down to game over.
        for (int k = 0; k < 2; k++) begin
            pulse_eaten();
            step(DYING_CYCLES + READY_CYCLES);
        end
        check("lives_one", bus.o_lives, 1);
        check("lives_one_play", bus.o_game_state, 3);
        pulse_eaten();
        check("lives_zero", bus.o_lives, 0);
        check("last_dying", bus.o_game_state, 5);
        step(DYING_CYCLES);
        check("gameover_state", bus.o_game_state, 7);
        check("gameover_ghost", bus.o_ghost_reload, 0);
        pulse_start();
        check("gameover_idle", bus.o_game_state, 0);
        check("gameover_lives_hold", bus.o_lives, 0);
        pulse_start();
        check("restart_state", bus.o_game_state, 1);
        check("restart_lives", bus.o_lives, 3);
        check("restart_level", bus.o_level, 1);

        // Climb to the level limit.
        for (int lv = 1; lv < 255; lv++) begin
            pulse_done();
            step(READY_CYCLES);
            pulse_clear();
            pulse_start();
        end
        check("level_max", bus.o_level, 255);
        pulse_done();
        step(READY_CYCLES);
        pulse_clear();
        check("clear_state", bus.o_game_state, 6);
        pulse_start();
        check("level_sat_state", bus.o_game_state, 1);
        check("level_sat", bus.o_level, 255);
        check("level_sat_lives", bus.o_lives, 3);

        // Reset while dying.
        pulse_done();
        step(READY_CYCLES);
        pulse_eaten();
        check("pre_rst_dying", bus.o_game_state, 5);
        step(10);
        rst = 1'b1; step(1); rst = 1'b0;
        check("rst_dying_state", bus.o_game_state, 0);
        check("rst_dying_level", bus.o_level, 1);
        check("rst_dying_lives", bus.o_lives, 3);
        check("rst_dying_board", bus.o_board_reload, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
